// File: rtl/wb_trace_pkg.sv
// Shared types and helpers for the write-back trace UART transmitter.
package wb_trace_pkg;

  // Per-byte serializer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // Frame sequencer states: waiting for an entry, or streaming its bytes
  typedef enum logic {
    FR_IDLE = 1'b0,
    FR_SEND = 1'b1
  } frame_state_e;

  localparam int FRAME_BYTES = 5;
  localparam int RD_W        = 5;
  localparam int DATA_W      = 32;
  localparam int ENTRY_W     = RD_W + DATA_W;

  // Byte idx of the frame for one {rd, data} entry: rd first, then data MSB first
  function automatic logic [7:0] frame_byte(input logic [ENTRY_W-1:0] entry,
                                            input logic [2:0]         idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = {3'b000, entry[ENTRY_W-1:DATA_W]};
      3'd1:    b = entry[31:24];
      3'd2:    b = entry[23:16];
      3'd3:    b = entry[15:8];
      default: b = entry[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 serializer for a single byte. A start request arriving on the last
// cycle of the stop bit chains the next byte with no idle gap.
module uart_tx_byte
  import wb_trace_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  uart_state_e       state;
  logic [BAUD_W-1:0] baud;
  logic [2:0]        bit_idx;
  logic [7:0]        shreg;
  logic              baud_end;

  assign baud_end = (baud == BAUD_LAST);
  assign done     = (state == ST_STOP) && baud_end;

  // Bit-timing FSM; tx is registered and the baud counter restarts on every state entry
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          baud <= '0;
          if (start) begin
            shreg <= data;
            state <= ST_START;
            tx    <= 1'b0;
          end
        end
        ST_START: begin
          if (baud_end) begin
            baud    <= '0;
            bit_idx <= '0;
            state   <= ST_DATA;
            tx      <= shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        ST_DATA: begin
          if (baud_end) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        ST_STOP: begin
          if (baud_end) begin
            baud <= '0;
            if (start) begin
              shreg <= data;
              state <= ST_START;
              tx    <= 1'b0;
            end else begin
              state <= ST_IDLE;
              tx    <= 1'b1;
            end
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/wb_uart_tx.sv
// Write-back trace transmitter: captures retired register writes into a FIFO
// and streams each as a 5-byte UART frame. The core is never stalled; writes
// that find the FIFO full are dropped and latched in a sticky overflow flag.
module wb_uart_tx
  import wb_trace_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int DEPTH        = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_en,
  input  logic [4:0]               wb_rd,
  input  logic [31:0]              wb_data,
  output logic                     tx,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [2:0] LAST_BYTE = 3'(FRAME_BYTES - 1);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] head;
  logic [ENTRY_W-1:0] hold;
  logic [PTR_W-1:0]   wptr;
  logic [PTR_W-1:0]   rptr;
  logic [2:0]         byte_idx;
  frame_state_e       fstate;

  logic push_req, push, pop, drop, empty, full;
  logic byte_start, byte_done;
  logic [7:0] byte_data;

  assign head     = mem[rptr];
  assign empty    = (level == '0);
  assign full     = (level == LVL_W'(DEPTH));
  assign push_req = wb_en && (wb_rd != 5'd0);
  assign pop      = (fstate == FR_IDLE) && !empty;
  // A full FIFO still accepts a write when the head leaves on the same edge
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  // Pick what the serializer sends next: first byte of a fresh entry, or the following byte of the held one
  always_comb begin
    byte_start = 1'b0;
    byte_data  = 8'h00;
    if (pop) begin
      byte_start = 1'b1;
      byte_data  = frame_byte(head, 3'd0);
    end else if ((fstate == FR_SEND) && byte_done && (byte_idx < LAST_BYTE)) begin
      byte_start = 1'b1;
      byte_data  = frame_byte(hold, byte_idx + 3'd1);
    end
  end

  // FIFO storage and the entry being framed; data only, no reset needed
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {wb_rd, wb_data};
    if (pop)  hold      <= head;
  end

  // FIFO pointers, occupancy, overflow flag and frame sequencer
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      overflow <= 1'b0;
      fstate   <= FR_IDLE;
      busy     <= 1'b0;
      byte_idx <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      if (push && !pop)      level <= level + LVL_W'(1);
      else if (pop && !push) level <= level - LVL_W'(1);
      if (drop) overflow <= 1'b1;

      case (fstate)
        FR_IDLE: begin
          if (pop) begin
            fstate   <= FR_SEND;
            busy     <= 1'b1;
            byte_idx <= '0;
          end
        end
        FR_SEND: begin
          if (byte_done) begin
            if (byte_idx < LAST_BYTE) begin
              byte_idx <= byte_idx + 3'd1;
            end else begin
              fstate <= FR_IDLE;
              busy   <= 1'b0;
            end
          end
        end
        default: begin
          fstate <= FR_IDLE;
          busy   <= 1'b0;
        end
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk   (clk),
    .rst   (rst),
    .start (byte_start),
    .data  (byte_data),
    .tx    (tx),
    .done  (byte_done)
  );

endmodule

// File: tb/tb_wb_uart_tx.sv
// Bench for wb_uart_tx: a transaction-level model decides which writes are
// accepted and when frames begin; a UART monitor decodes the line and checks
// each frame against the queue of accepted entries.
module tb_wb_uart_tx;

  localparam int CPB     = 4;
  localparam int DEPTH   = 4;
  localparam int FRAME_T = 50 * CPB;
  localparam int BYTE_T  = 10 * CPB;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   wb_en;
  logic [4:0]             wb_rd;
  logic [31:0]            wb_data;
  logic                   tx;
  logic                   busy;
  logic [$clog2(DEPTH):0] level;
  logic                   overflow;

  wb_uart_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .wb_en    (wb_en),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .tx       (tx),
    .busy     (busy),
    .level    (level),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model state
  logic [36:0] mq[$];      // entries waiting in the FIFO
  logic [36:0] exp_q[$];   // accepted entries not yet seen on the line
  int  cyc      = 0;
  int  t_free   = 0;
  int  last_pop = -1000;
  int  rst_gen  = 0;
  bit  ovf_m    = 1'b0;

  // Monitor results
  bit          mon_active = 1'b0;
  logic [4:0]  last_rd    = '0;
  logic [31:0] last_data  = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive inputs, advance the model for the coming edge, check after it
  task automatic step(input bit r, input bit en, input logic [4:0] rd, input logic [31:0] d);
    bit pop_m;
    bit busy_m;
    logic [36:0] tmp;
    @(negedge clk);
    rst = r; wb_en = en; wb_rd = rd; wb_data = d;
    if (r) begin
      mq.delete(); exp_q.delete();
      ovf_m = 1'b0; t_free = cyc + 1; last_pop = -1000; rst_gen++;
    end else begin
      pop_m = (cyc >= t_free) && (mq.size() > 0);
      if (pop_m) begin
        tmp = mq.pop_front();
        last_pop = cyc;
        t_free = cyc + FRAME_T + 1;
      end
      if (en && rd != 5'd0) begin
        if (mq.size() < DEPTH) begin
          mq.push_back({rd, d});
          exp_q.push_back({rd, d});
        end else begin
          ovf_m = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    busy_m = (cyc >= last_pop) && (cyc < last_pop + FRAME_T);
    chk("level", 64'(level), 64'(mq.size()));
    chk("overflow", 64'(overflow), 64'(ovf_m));
    chk("busy", 64'(busy), 64'(busy_m));
    if (!busy_m) chk("tx_idle_high", 64'(tx), 64'(1));
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() > 0 || mon_active) && n < 3000) begin
      step(1'b0, 1'b0, 5'd0, 32'd0);
      n++;
    end
    n_cmp++;
    if (n >= 3000) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d frames still pending, expected 0", exp_q.size());
    end
    idle(3);
  endtask

  // UART monitor: sample each bit at its centre, compare whole frames
  logic [9:0]  sym [5];
  logic [36:0] ent;
  logic [39:0] ebytes;
  initial begin : monitor
    int g;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        g = rst_gen;
        mon_active = 1'b1;
        for (int off = 0; off < FRAME_T; off++) begin
          if (off > 0) @(negedge clk);
          if (off % CPB == CPB / 2) sym[off / BYTE_T][(off % BYTE_T) / CPB] = tx;
        end
        if (g == rst_gen) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_frame: got rd 0x%0h, expected no frame", sym[0][5:1]);
          end else begin
            ent = exp_q.pop_front();
            ebytes = {3'b000, ent[36:32], ent[31:0]};
            for (int b = 0; b < 5; b++)
              chk($sformatf("frame_byte%0d", b), 64'(sym[b]),
                  64'({1'b1, ebytes[39 - 8*b -: 8], 1'b0}));
            last_rd   = sym[0][5:1];
            last_data = {sym[1][8:1], sym[2][8:1], sym[3][8:1], sym[4][8:1]};
          end
        end
        mon_active = 1'b0;
      end
    end
  end

  initial begin
    rst = 1'b1; wb_en = 1'b0; wb_rd = '0; wb_data = '0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 5'd0, 32'd0);
    chk("reset_tx", 64'(tx), 64'(1));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_level", 64'(level), 64'(0));
    chk("reset_overflow", 64'(overflow), 64'(0));
    idle(2);

    // Single write
    step(1'b0, 1'b1, 5'd1, 32'h0000_0004);
    chk("single_level", 64'(level), 64'(1));
    step(1'b0, 1'b0, 5'd0, 32'd0);
    chk("single_start_bit", 64'(tx), 64'(0));
    drain();
    chk("single_last_rd", 64'(last_rd), 64'(1));
    chk("single_last_data", 64'(last_data), 64'(32'h4));

    // rd = 0 is filtered
    step(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    chk("rd0_level", 64'(level), 64'(0));
    chk("rd0_tx", 64'(tx), 64'(1));
    chk("rd0_overflow", 64'(overflow), 64'(0));
    idle(5);

    // Overflow: six back-to-back writes, the sixth is dropped
    for (int i = 1; i <= 6; i++) begin
      step(1'b0, 1'b1, 5'(i), $urandom);
      if (i == 5) chk("ovf_level_full", 64'(level), 64'(4));
    end
    chk("ovf_flag", 64'(overflow), 64'(1));
    chk("ovf_level_after_drop", 64'(level), 64'(4));
    drain();
    chk("ovf_flag_sticky", 64'(overflow), 64'(1));

    // Simultaneous push and pop at full
    step(1'b1, 1'b0, 5'd0, 32'd0);
    for (int i = 11; i <= 15; i++) step(1'b0, 1'b1, 5'(i), $urandom);
    chk("full_level", 64'(level), 64'(4));
    begin
      int n = 0;
      while (cyc < t_free && n < 1000) begin
        step(1'b0, 1'b0, 5'd0, 32'd0);
        n++;
      end
    end
    step(1'b0, 1'b1, 5'd7, 32'h7777_7777);
    chk("pushpop_level", 64'(level), 64'(4));
    chk("pushpop_overflow", 64'(overflow), 64'(0));
    drain();

    // Reset mid-frame, during the data bits of the third byte
    step(1'b0, 1'b1, 5'd9, 32'h1234_5678);
    idle(90);
    step(1'b1, 1'b0, 5'd0, 32'd0);
    chk("midrst_tx", 64'(tx), 64'(1));
    chk("midrst_level", 64'(level), 64'(0));
    idle(250);
    step(1'b0, 1'b1, 5'd3, 32'hDEAD_BEEF);
    drain();
    chk("midrst_rd", 64'(last_rd), 64'(3));
    chk("midrst_data", 64'(last_data), 64'(32'hDEAD_BEEF));

    // Randomized traffic, including rd = 0 and overflowing bursts
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0)
        step(1'b0, 1'b1, 5'($urandom_range(0, 31)), $urandom);
      else if ($urandom_range(0, 99) == 0)
        for (int k = 0; k < 6; k++) step(1'b0, 1'b1, 5'($urandom_range(0, 31)), $urandom);
      else
        step(1'b0, 1'b0, 5'd0, 32'd0);
    end
    drain();

    // Core program replay: x1 accumulates x2 until it reaches 16
    step(1'b1, 1'b0, 5'd0, 32'd0);
    begin
      logic [4:0]  prd [8] = '{5'd1, 5'd2, 5'd0, 5'd1, 5'd1, 5'd3, 5'd1, 5'd1};
      logic [31:0] pdt [8] = '{32'd0, 32'd4, 32'd5, 32'd4, 32'd8, 32'd8, 32'd12, 32'd16};
      for (int i = 0; i < 8; i++) begin
        step(1'b0, 1'b1, prd[i], pdt[i]);
        idle(210);
      end
    end
    drain();
    chk("replay_rd", 64'(last_rd), 64'(1));
    chk("replay_data", 64'(last_data), 64'(32'h10));
    chk("replay_overflow", 64'(overflow), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
